rgb_fade_sequencer: RTL
=======================

// Module: rgb_fade_sequencer
// PURPOSE
//  Controller between the three encoder value registers and the three PWM level
//  inputs of the RGB mixer. Slews each PWM level toward a per-mode target at a
//  fixed rate, so colour changes fade instead of stepping. Modes, stepped by a
//  debounced mode button:
//  - MANUAL: targets are the encoder values.
//  - CYCLE: auto R->G->B colour sequence.
//  - OFF: all targets are 0.
// PARAMETERS
//  TICK_DIV  1000  clk cycles per ramp tick (>=2)
//  STEP      1     max level change per tick, per channel (1..255)
//  DWELL     64    ticks held at each CYCLE phase once all channels have settled
// PORTS
//  clk       in   1  system clock, rising edge
//  reset     in   1  synchronous, active-high; sampled on rising clk only
//  enc0      in   8  red encoder value (MANUAL target / CYCLE red brightness)
//  enc1      in   8  green encoder value
//  enc2      in   8  blue encoder value
//  mode_btn  in   1  debounced mode button, level; rising edge advances mode
//  level0    out  8  red PWM level, registered
//  level1    out  8  green PWM level, registered
//  level2    out  8  blue PWM level, registered
//  mode      out  2  00=MANUAL 01=CYCLE 10=OFF (11 never driven)
//  busy      out  1  registered; 1 while any levelN != its current target
// BEHAVIOUR
//  Reset values:
//  - level0/1/2=0, mode=MANUAL, busy=0.
//  - Tick counter=0, dwell counter=0, phase=RED, button edge register=0.
//  Tick:
//  - Counter runs 0..TICK_DIV-1 and wraps.
//  - Internal tick=1 for exactly one cycle when counter==TICK_DIV-1.
//  Ramp, on each tick, per channel, tgt = current target:
//  - If level<tgt: level += min(STEP, tgt-level).
//  - If level>tgt: level -= min(STEP, level-tgt).
//  - Never overshoots; 8-bit unsigned; diff computed 9-bit, so no wrap.
//  - Levels change only on tick cycles.
//  Targets, combinational from the current state:
//  - MANUAL: {enc0, enc1, enc2}.
//  - OFF: {0, 0, 0}.
//  - CYCLE, phase RED: {enc0, 0, 0}; GREEN: {0, enc1, 0}; BLUE: {0, 0, enc2}.
//  Phase FSM (CYCLE only), RED->GREEN->BLUE->RED:
//  - Dwell counter increments on ticks while all levels == targets.
//  - Dwell counter clears when any level differs from its target.
//  - When dwell counter == DWELL-1 on a tick: advance phase and clear dwell.
//  - Entering CYCLE always restarts at phase RED with dwell=0.
//  Mode FSM:
//  - mode_btn rising edge (btn & ~btn_q) advances MANUAL->CYCLE->OFF->MANUAL.
//  - New mode is visible on `mode` the cycle after the edge.
//  - Levels continue ramping from their current values; no jump to target.
//  Simultaneous events:
//  - Button edge on a tick cycle: that tick's ramp uses the OLD mode's targets.
//  - Encoder changes mid-ramp retarget immediately.
//  - busy is registered: it reflects the previous cycle's comparison (1 cycle late).
//  Reset mid-ramp: all state returns to reset values on the next edge.
// CONFIGURATION
//  RGB_SEQ_OFF_EN defined:
//  - Three modes as above.
//  RGB_SEQ_OFF_EN undefined:
//  - OFF mode not built; button toggles MANUAL<->CYCLE.
//  - mode is only ever 00 or 01.
// TESTING  (TICK_DIV=4, STEP=16, DWELL=2 unless noted)
//  1 Reset: hold reset 3 cycles -> levels 0, mode=00, busy=0; tick at 4th cycle after release.
//  2 Ramp: enc0=40 in MANUAL -> level0 = 16, 32, 40 on successive ticks, then stays 40; busy falls 1 cycle after 40.
//  3 Down ramp and STEP clamp: level1=200, enc1=195 -> level1=195 after one tick.
//  4 Modes: 3 button edges -> mode 01, 10, 00; OFF ramps all levels to 0; undefined macro -> mode 01, 00, 01.
//  5 Cycle: enc={32,32,32}, enter CYCLE -> red reaches 32, holds 2 ticks, then fades to 0 while green rises; sequence RED->GREEN->BLUE->RED.
//  6 Reset mid-ramp (level2=48 rising) -> next cycle level2=0, mode=00, phase RED.

Source files
------------

// File: rtl/rgb_fade_sequencer.sv
// RGB fade sequencer: slews three PWM levels toward per-mode targets once per ramp tick.
// Optional OFF mode is built when RGB_SEQ_OFF_EN is defined; otherwise the button toggles MANUAL<->CYCLE.
module rgb_fade_sequencer #(
    parameter int TICK_DIV = 1000,
    parameter int STEP     = 1,
    parameter int DWELL    = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] enc0,
    input  logic [7:0] enc1,
    input  logic [7:0] enc2,
    input  logic       mode_btn,
    output logic [7:0] level0,
    output logic [7:0] level1,
    output logic [7:0] level2,
    output logic [1:0] mode,
    output logic       busy
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [8:0]    STEP9      = 9'(STEP);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_CYCLE  = 2'b01,
        MODE_OFF    = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        PH_RED   = 2'b00,
        PH_GREEN = 2'b01,
        PH_BLUE  = 2'b10
    } phase_t;

    mode_t         mode_q, mode_d;
    phase_t        phase_q, phase_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [TW-1:0] tick_cnt;
    logic          btn_q;
    logic          tick;
    logic          btn_edge;
    logic          settled;
    logic [7:0]    tgt0, tgt1, tgt2;

    assign tick     = (tick_cnt == TICK_LAST);
    assign btn_edge = mode_btn & ~btn_q;
    assign settled  = (level0 == tgt0) && (level1 == tgt1) && (level2 == tgt2);
    assign mode     = mode_q;

    // Move one step toward the target; the difference is 9-bit so it never wraps.
    function automatic logic [7:0] ramp(input logic [7:0] lvl, input logic [7:0] tgt);
        logic [8:0] diff;
        logic [7:0] r;
        r    = lvl;
        diff = '0;
        if (lvl < tgt) begin
            diff = {1'b0, tgt} - {1'b0, lvl};
            r    = (diff > STEP9) ? lvl + STEP9[7:0] : tgt;
        end else if (lvl > tgt) begin
            diff = {1'b0, lvl} - {1'b0, tgt};
            r    = (diff > STEP9) ? lvl - STEP9[7:0] : tgt;
        end
        return r;
    endfunction

    always_comb begin
        tgt0 = '0;
        tgt1 = '0;
        tgt2 = '0;
        case (mode_q)
            MODE_MANUAL: begin
                tgt0 = enc0;
                tgt1 = enc1;
                tgt2 = enc2;
            end
            MODE_CYCLE: begin
                case (phase_q)
                    PH_RED:   tgt0 = enc0;
                    PH_GREEN: tgt1 = enc1;
                    default:  tgt2 = enc2;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        mode_d = mode_q;
        if (btn_edge) begin
            case (mode_q)
                MODE_MANUAL: mode_d = MODE_CYCLE;
`ifdef RGB_SEQ_OFF_EN
                MODE_CYCLE:  mode_d = MODE_OFF;
`else
                MODE_CYCLE:  mode_d = MODE_MANUAL;
`endif
                default:     mode_d = MODE_MANUAL;
            endcase
        end
    end

    // Dwell only accumulates on ticks where every channel already sits on its target.
    always_comb begin
        phase_d = phase_q;
        dwell_d = dwell_q;
        if (btn_edge && (mode_d == MODE_CYCLE)) begin
            phase_d = PH_RED;
            dwell_d = '0;
        end else if (mode_q != MODE_CYCLE) begin
            phase_d = PH_RED;
            dwell_d = '0;
        end else if (!settled) begin
            dwell_d = '0;
        end else if (tick) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                case (phase_q)
                    PH_RED:   phase_d = PH_GREEN;
                    PH_GREEN: phase_d = PH_BLUE;
                    default:  phase_d = PH_RED;
                endcase
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            btn_q    <= 1'b0;
            mode_q   <= MODE_MANUAL;
            phase_q  <= PH_RED;
            dwell_q  <= '0;
            level0   <= '0;
            level1   <= '0;
            level2   <= '0;
            busy     <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            btn_q    <= mode_btn;
            mode_q   <= mode_d;
            phase_q  <= phase_d;
            dwell_q  <= dwell_d;
            busy     <= ~settled;
            if (tick) begin
                level0 <= ramp(level0, tgt0);
                level1 <= ramp(level1, tgt1);
                level2 <= ramp(level2, tgt2);
            end
        end
    end

endmodule
